// File: rtl/mvu_csr_apb_master_if.sv
// APB bus bundle between the CSR write master and the MVU register file.
// The master drives the address, data and control lines; the completer answers.
interface mvu_csr_apb_master_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output pready, pslverr
  );
endinterface

// File: rtl/mvu_csr_apb_master.sv
// Write-only APB master that drains a small request queue of MVU CSR writes.
// Requests are queued in order; each becomes one SETUP/ACCESS transfer, with
// back-to-back transfers when the queue stays non-empty.  A completer that
// never raises pready is abandoned after TIMEOUT access cycles.
module mvu_csr_apb_master #(
  parameter int APB_ADDR_WIDTH = 15,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_data,
  mvu_csr_apb_master_if.master      apb,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr,
  output logic [15:0]               wr_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = APB_ADDR_WIDTH + APB_DATA_WIDTH;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_reg, state_next;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty, push, pop;

  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg;
  logic [WAIT_W-1:0]         wait_reg, wait_next;
  logic                      complete, abort;
  logic                      err_reg;
  logic [15:0]               wr_count_reg;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign push       = req_valid && !fifo_full;
  assign head       = mem[rd_ptr_reg[PTR_W-1:0]];

  // Queue storage: written on accept, no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= {req_addr, req_data};
    end
  end

  // Next-state logic: decides pops, completions and timeout aborts.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    pop        = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        wait_next  = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (apb.pready) begin
          complete = 1'b1;
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
        // Finishing either way chains straight into the next queued write.
        if (complete || abort) begin
          wait_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, queue pointers, APB holding registers, error and transfer count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
      wait_reg     <= '0;
      err_reg      <= 1'b0;
      wr_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (PTR_W + 1)'(1);
        paddr_reg  <= head[ENTRY_W-1:APB_DATA_WIDTH];
        pwdata_reg <= head[APB_DATA_WIDTH-1:0];
      end
      if (complete) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      // A new error wins over a same-cycle clear.
      if ((complete && apb.pslverr) || abort) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign apb.paddr   = paddr_reg;
  assign apb.pwdata  = pwdata_reg;
  assign apb.psel    = (state_reg != IDLE);
  assign apb.penable = (state_reg == ACCESS);
  assign apb.pwrite  = 1'b1;

  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_reg != IDLE);
  assign err       = err_reg;
  assign wr_count  = wr_count_reg;

endmodule
